// File: rtl/basic_ndro_sync_pkg.sv
// Shared constants and types for the synchronous NDRO cell model.
// Event indices address the per-input detector vector in basic_ndro_sync.
package basic_ndro_pkg;

  localparam int EV_SET   = 0;
  localparam int EV_RESET = 1;
  localparam int EV_RD    = 2;
  localparam int N_EV     = 3;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int MIN_GAP_DEF     = 2;

  typedef logic [7:0] viol_cnt_t;

  function automatic viol_cnt_t sat_inc8(input viol_cnt_t v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/basic_ndro_sync_toggle_event_detect.sv
// Synchronizer chain plus previous-value flop for one toggle-encoded input.
// ev is a one-cycle strobe for every transition seen at the end of the chain.
module toggle_event_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic ev
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // prev resets to 0, so an input already high at reset release yields one event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ev = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/basic_ndro_sync.sv
// Synchronous RSFQ non-destructive-readout cell: set/reset store a bit, rd toggles out when it is 1.
// Optional read-timing checker (err, viol_cnt) built when NDRO_TIMING_CHECK_EN is defined.
module basic_ndro_sync
  import basic_ndro_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int RESET_WINS  = 1,
  parameter int MIN_GAP     = MIN_GAP_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set,
  input  logic      reset,
  input  logic      rd,
  output logic      out,
  output logic      state_o,
  output logic      err
`ifdef NDRO_TIMING_CHECK_EN
  ,output viol_cnt_t viol_cnt
`endif
);

  if (SYNC_STAGES < 1 || SYNC_STAGES > 4 || MIN_GAP < 1) begin : g_bad_param
    $error("basic_ndro_sync: SYNC_STAGES must be 1..4 and MIN_GAP >= 1");
  end

  logic [N_EV-1:0] din;
  logic [N_EV-1:0] ev;

  assign din[EV_SET]   = set;
  assign din[EV_RESET] = reset;
  assign din[EV_RD]    = rd;

  for (genvar g = 0; g < N_EV; g++) begin : g_det
    toggle_event_detect #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_det (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (din[g]),
      .ev   (ev[g])
    );
  end

  logic state_q, state_nxt;
  logic out_q, out_nxt;

  // read-before-write: out toggles from the state held before this cycle's set/reset
  always_comb begin
    state_nxt = state_q;
    out_nxt   = out_q ^ (ev[EV_RD] & state_q);
    if (ev[EV_SET] && ev[EV_RESET]) begin
      state_nxt = (RESET_WINS != 0) ? 1'b0 : 1'b1;
    end else if (ev[EV_SET]) begin
      state_nxt = 1'b1;
    end else if (ev[EV_RESET]) begin
      state_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      out_q   <= out_nxt;
    end
  end

  assign out     = out_q;
  assign state_o = state_q;

`ifdef NDRO_TIMING_CHECK_EN
  localparam int CW = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

  logic [CW-1:0] gap_q;
  logic          sr_ev;
  logic          viol;
  logic          err_q;
  viol_cnt_t     viol_cnt_q;

  assign sr_ev = ev[EV_SET] | ev[EV_RESET];
  assign viol  = ev[EV_RD] & (sr_ev | (gap_q < CW'(MIN_GAP)));

  // gap_q = cycles elapsed since the last set/reset detection (reset counts as one), saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q      <= '0;
      err_q      <= 1'b0;
      viol_cnt_q <= '0;
    end else begin
      if (sr_ev) begin
        gap_q <= CW'(1);
      end else if (gap_q < CW'(MIN_GAP)) begin
        gap_q <= gap_q + CW'(1);
      end
      if (viol) begin
        err_q      <= 1'b1;
        viol_cnt_q <= sat_inc8(viol_cnt_q);
      end
    end
  end

  assign err      = err_q;
  assign viol_cnt = viol_cnt_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_basic_ndro_sync.sv
// Self-checking bench for basic_ndro_sync: directed scenarios plus randomized toggles
// against an event-schedule reference model; two DUTs cover both RESET_WINS settings.
module tb_basic_ndro_sync;
  import basic_ndro_pkg::*;

  localparam int SS  = 2;
  localparam int MG  = 2;
  localparam int LAT = SS + 1;

  localparam bit [2:0] M_SET = 3'b001;
  localparam bit [2:0] M_RST = 3'b010;
  localparam bit [2:0] M_RD  = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set = 1'b0, reset = 1'b0, rd = 1'b0;
  logic out1, st1, err1, out2, st2, err2;
`ifdef NDRO_TIMING_CHECK_EN
  viol_cnt_t vc1, vc2;
`endif

  always #5 clk = ~clk;

  basic_ndro_sync #(.SYNC_STAGES(SS), .RESET_WINS(1), .MIN_GAP(MG)) u_dut_rw1 (
    .clk(clk), .rst_n(rst_n), .set(set), .reset(reset), .rd(rd),
    .out(out1), .state_o(st1), .err(err1)
`ifdef NDRO_TIMING_CHECK_EN
    , .viol_cnt(vc1)
`endif
  );

  basic_ndro_sync #(.SYNC_STAGES(SS), .RESET_WINS(0), .MIN_GAP(MG)) u_dut_rw0 (
    .clk(clk), .rst_n(rst_n), .set(set), .reset(reset), .rd(rd),
    .out(out2), .state_o(st2), .err(err2)
`ifdef NDRO_TIMING_CHECK_EN
    , .viol_cnt(vc2)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;
  bit in_rst = 1'b1;

  // events keyed by the clock edge on which they take effect
  bit [2:0] sched [int];
  logic mst1, mout1, mst2, mout2, merr;
  int   mvc;
  int   last_sr;
  int   last_tog [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    mst1 = 1'b0; mout1 = 1'b0; mst2 = 1'b0; mout2 = 1'b0;
    merr = 1'b0; mvc = 0;
    sched.delete();
  endtask

  task automatic model_apply();
    bit [2:0] m;
    bit sr;
    if (in_rst || !sched.exists(edge_cnt)) return;
    m = sched[edge_cnt];
    sched.delete(edge_cnt);
    sr = m[EV_SET] | m[EV_RESET];
`ifdef NDRO_TIMING_CHECK_EN
    if (m[EV_RD] && (sr || (edge_cnt - last_sr) < MG)) begin
      merr = 1'b1;
      if (mvc < 255) mvc++;
    end
`endif
    if (sr) last_sr = edge_cnt;
    if (m[EV_RD]) begin
      mout1 = mout1 ^ mst1;
      mout2 = mout2 ^ mst2;
    end
    if (m[EV_SET] && m[EV_RESET]) begin
      mst1 = 1'b0; mst2 = 1'b1;
    end else if (m[EV_SET]) begin
      mst1 = 1'b1; mst2 = 1'b1;
    end else if (m[EV_RESET]) begin
      mst1 = 1'b0; mst2 = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("out_rw1", out1, mout1);
    chk("state_rw1", st1, mst1);
    chk("out_rw0", out2, mout2);
    chk("state_rw0", st2, mst2);
    chk("err_rw1", err1, merr);
    chk("err_rw0", err2, merr);
`ifdef NDRO_TIMING_CHECK_EN
    chk("viol_cnt_rw1", vc1, mvc);
    chk("viol_cnt_rw0", vc2, mvc);
`endif
  endtask

  task automatic schedule(input bit [2:0] tog);
    int k;
    k = edge_cnt + LAT;
    if (!sched.exists(k)) sched[k] = 3'b000;
    sched[k] = sched[k] | tog;
    for (int i = 0; i < 3; i++) if (tog[i]) last_tog[i] = edge_cnt;
  endtask

  // one clock: advance model at the edge, check at the falling edge, then drive toggles
  task automatic cycle(input bit [2:0] tog);
    @(posedge clk);
    edge_cnt++;
    model_apply();
    @(negedge clk);
    check_all();
    set   = set   ^ tog[EV_SET];
    reset = reset ^ tog[EV_RESET];
    rd    = rd    ^ tog[EV_RD];
    if (!in_rst && tog != 3'b000) schedule(tog);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(3'b000);
  endtask

  task automatic release_rst();
    bit [2:0] lvl;
    lvl = {rd, reset, set};
    rst_n   = 1'b1;
    in_rst  = 1'b0;
    last_sr = edge_cnt + 1;
    if (lvl != 3'b000) schedule(lvl);
  endtask

  task automatic do_reset(input int hold, input bit [2:0] lvl);
    #2;
    rst_n  = 1'b0;
    in_rst = 1'b1;
    set = lvl[EV_SET]; reset = lvl[EV_RESET]; rd = lvl[EV_RD];
    model_clear();
    #1;
    chk("async_out", out1, 1'b0);
    chk("async_state", st1, 1'b0);
    chk("async_err", err1, 1'b0);
    chk("async_out_rw0", out2, 1'b0);
    idle(hold);
    release_rst();
  endtask

  initial begin
    bit [2:0] tog;
    model_clear();
    for (int i = 0; i < 3; i++) last_tog[i] = -100;

    idle(3);
    chk("rst_out", out1, 1'b0);
    chk("rst_state", st1, 1'b0);
    release_rst();
    idle(2);

    // set, then rd ten cycles later
    cycle(M_SET);
    idle(2);
    chk("t1_state_early", st1, 1'b0);
    idle(1);
    chk("t1_state_lat", st1, 1'b1);
    idle(6);
    cycle(M_RD);
    idle(2);
    chk("t1_out_early", out1, 1'b0);
    idle(1);
    chk("t1_out_lat", out1, 1'b1);
    idle(6);

    // set, set, reset, reset, rd: state ends 0 and out holds
    cycle(M_SET); idle(9);
    cycle(M_SET); idle(9);
    cycle(M_RST); idle(9);
    cycle(M_RST); idle(9);
    cycle(M_RD);  idle(9);
    chk("t2_state", st1, 1'b0);
    chk("t2_out", out1, 1'b1);

    // set then three reads: out 1->0->1->0
    cycle(M_SET); idle(9);
    for (int i = 0; i < 3; i++) begin
      cycle(M_RD); idle(4);
      chk("t3_state", st1, 1'b1);
    end
    idle(5);
    chk("t3_out", out1, 1'b0);

    // simultaneous set and reset
    cycle(M_SET | M_RST); idle(9);
    chk("t4_reset_wins", st1, 1'b0);
    chk("t4_set_wins", st2, 1'b1);

    // set + rd in the same cycle from state 0
    cycle(M_RST); idle(9);
    cycle(M_SET | M_RD); idle(9);
    chk("t5_out_rbw", out1, 1'b0);
    chk("t5_state", st1, 1'b1);
`ifdef NDRO_TIMING_CHECK_EN
    chk("t5_err", err1, 1'b1);
    chk("t5_viol_cnt", vc1, 8'd1);
`endif
    cycle(M_RD); idle(9);
    chk("t5_out_next", out1, 1'b1);

    // asynchronous reset with state=1, out=1
    do_reset(3, 3'b000);
    idle(10);
    chk("t6_state", st1, 1'b0);
    chk("t6_out", out1, 1'b0);
    chk("t6_err", err1, 1'b0);

    // input high at release counts as one event
    do_reset(2, M_SET);
    idle(LAT);
    chk("t7_state", st1, 1'b1);
    idle(5);

    // randomized traffic with occasional resets
    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 600; c++) begin
        tog = 3'b000;
        for (int i = 0; i < 3; i++) begin
          if (edge_cnt - last_tog[i] >= 2 && $urandom_range(0, 3) == 0) tog[i] = 1'b1;
        end
        cycle(tog);
      end
      do_reset($urandom_range(1, 4), 3'($urandom_range(0, 7)));
    end
    idle(LAT + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/basic_ndro_sync.md
Name: basic_ndro_sync

Overview:
Synchronous digital model of an RSFQ non-destructive-readout (NDRO) cell, for use in mixed-signal and SFQ-emulation fabrics.
- Set/reset events store a single bit; a read event returns that bit without disturbing it.
- Events on inputs and output use transition (toggle) signalling: each edge (0→1 or 1→0) is one SFQ pulse.

Parameters:
SYNC_STAGES, 2, synchronizer depth per event input (legal 1..4).
RESET_WINS, 1, on simultaneous set and reset: 1 = reset wins, 0 = set wins.
MIN_GAP, 2, minimum clk cycles between a set/reset event and a read event (timing-check feature only).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
set  input  1  set event, toggle-encoded (asynchronous to clk).
reset  input  1  reset event, toggle-encoded (asynchronous to clk).
rd  input  1  read event (the SFQ "clock" pulse), toggle-encoded.
out  output  1  read result, toggle-encoded: toggles once per read while state = 1.
state_o  output  1  current stored bit (level, debug).
err  output  1  sticky timing-violation flag (0 when feature compiled out).

Behaviour:
- Reset (rst_n = 0, asynchronous assert): all synchronizer flops, previous-value flops, state, out, err and counters go to 0.
- Reset release is synchronous to clk. An input sitting at 1 at release counts as one event.
- Event detection, per input:
  - Chain of SYNC_STAGES flops followed by a prev flop.
  - Event = (last sync stage != prev), evaluated combinationally.
  - One event per input transition; two transitions inside one clk period may cancel, and the inputs' minimum spacing is ≥ 2 clk periods.
- State update on the rising edge after detection:
  - set event → state = 1.
  - reset event → state = 0.
  - Both in the same cycle → RESET_WINS decides.
  - Repeated set while state = 1 (or reset while 0) has no effect.
- Read: on a detected rd event, out inverts iff the pre-update state = 1 (read-before-write). If state = 0, out is unchanged. The read never modifies state.
- Latency:
  - Input edge → out toggle on the (SYNC_STAGES+1)th rising clk edge (3rd edge by default).
  - Input edge → state_o change on the same edge.
- Reset mid-operation: pending, undetected events are discarded; out returns to 0 immediately.

Optional Feature:
- Macro NDRO_TIMING_CHECK_EN.
- When defined:
  - A cycle counter since the last set/reset event saturates at MIN_GAP.
  - A rd event detected while the counter is < MIN_GAP sets err = 1 (sticky until rst_n), and increments an 8-bit saturating violation count, exposed as viol_cnt[7:0].
  - A set/reset event in the same cycle as rd is a violation.
  - out behaviour is unchanged.
- When undefined: no counter, err tied 0, viol_cnt port absent.

Decomposition:
- Package basic_ndro_pkg:
  - Event index constants: EV_SET = 0, EV_RESET = 1, EV_RD = 2.
  - Default SYNC_STAGES and MIN_GAP constants.
  - 8-bit viol_cnt_t typedef.
- One sub-module, toggle_event_detect: synchronizer plus prev flop, outputs a 1-cycle event strobe. Instantiated three times.

Test Plan:
- Set toggle at t0, rd toggle 10 cycles later → state_o = 1 after 3 edges; out goes 0→1 3 edges after the rd toggle.
- Set, set, reset, reset (10-cycle spacing), then rd → state_o ends 0; out stays 0.
- Set, then rd ×3 spaced 5 cycles → out toggles 3 times (0→1→0→1); state_o stays 1 throughout.
- Set and reset toggled in the same cycle with RESET_WINS = 1 → state_o = 0. Repeat with RESET_WINS = 0 → state_o = 1.
- Set then rd in the same cycle, from state 0 → out unchanged (read-before-write), state_o = 1; next rd toggles out. With NDRO_TIMING_CHECK_EN: err = 1, viol_cnt = 1.
- State = 1 and out = 1, assert rst_n = 0 mid-stream → out, state_o and err = 0 asynchronously; after release with inputs held at 0, no events occur.
